// File: rtl/lpc_sniffer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lpc_sniffer_pkg
//  Description : Shared constants, state encoding and helpers for the
//                serial2mem / mem2serial frame path.
//  Revision    : 1.0 - initial release
// ============================================================================
package lpc_sniffer_pkg;

    localparam int          FRAME_BYTES  = 6;
    localparam logic [7:0]  TRAILER_BYTE = 8'h0a;
    localparam int          WORD_W       = 48;
    localparam int          BYTE_W       = 8;
    localparam int          CNT_W        = 3;
    localparam int          TIMEOUT_W    = 24;

    typedef enum logic [1:0] {
        COLLECT       = 2'd0,
        CHECK_TRAILER = 2'd1,
        WRITE         = 2'd2,
        HUNT          = 2'd3
    } s2m_state_t;

    // Event counters stick at all-ones instead of wrapping.
    function automatic logic [7:0] sat_inc(input logic [7:0] value);
        return (value == 8'hff) ? value : value + 8'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial2mem_timeout.sv
`default_nettype none
// ============================================================================
//  Module      : serial2mem_timeout
//  Description : Inter-byte idle counter. Counts falling edges since the last
//                clear and flags expiry once TIMEOUT is reached. Used only
//                when SERIAL2MEM_TIMEOUT_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial2mem_timeout
    import lpc_sniffer_pkg::*;
#(
    parameter logic [TIMEOUT_W-1:0] TIMEOUT = 24'd1200000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic expired
);

    logic [TIMEOUT_W-1:0] idle_cnt;

    // Idle counter: cleared by every byte strobe, holds once it hits TIMEOUT.
    always_ff @(negedge clock or negedge reset) begin
        if (!reset) begin
            idle_cnt <= '0;
        end else if (clear) begin
            idle_cnt <= '0;
        end else if (idle_cnt != TIMEOUT) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    assign expired = (idle_cnt == TIMEOUT);

endmodule
`default_nettype wire

// File: rtl/serial2mem.sv
`default_nettype none
// ============================================================================
//  Module      : serial2mem
//  Description : Assembles 6-byte frames terminated by 8'h0a from a UART byte
//                stream into 48-bit words and writes them to a FIFO. Counts
//                malformed frames and frames dropped on a full FIFO.
//                Optional feature macro: SERIAL2MEM_TIMEOUT_EN (idle timeout
//                that abandons partial frames).
//  Revision    : 1.0 - initial release
// ============================================================================
module serial2mem
    import lpc_sniffer_pkg::*;
#(
    parameter logic [TIMEOUT_W-1:0] TIMEOUT = 24'd1200000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [7:0]        uart_data,
    input  logic              uart_valid,
    input  logic              write_full,
    output logic [WORD_W-1:0] write_data,
    output logic              write_clock_enable,
    output logic [7:0]        frame_error_count,
    output logic [7:0]        overflow_count
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_BYTES - 1);

    s2m_state_t        state;
    s2m_state_t        next_state;
    logic [CNT_W-1:0]  byte_cnt;
    logic [WORD_W-1:0] shift_reg;

    logic shift_en;
    logic cnt_clear;
    logic err_inc;
    logic ovf_inc;
    logic write_en;
    logic idle_expired;

`ifdef SERIAL2MEM_TIMEOUT_EN
    serial2mem_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clock   (clock),
        .reset   (reset),
        .clear   (uart_valid),
        .expired (idle_expired)
    );
`else
    // No idle tracking: partial frames wait forever for their next byte.
    logic timeout_unused;
    assign timeout_unused = ^TIMEOUT;
    assign idle_expired   = 1'b0;
`endif

    // State register.
    always_ff @(negedge clock or negedge reset) begin
        if (!reset) begin
            state <= COLLECT;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and datapath control decode.
    always_comb begin
        next_state = state;
        shift_en   = 1'b0;
        cnt_clear  = 1'b0;
        err_inc    = 1'b0;
        ovf_inc    = 1'b0;
        write_en   = 1'b0;
        case (state)
            COLLECT: begin
                // Every byte here is payload, including 8'h0a.
                if (uart_valid) begin
                    shift_en = 1'b1;
                    if (byte_cnt == LAST_IDX) begin
                        next_state = CHECK_TRAILER;
                    end
                end else if (idle_expired && (byte_cnt != '0)) begin
                    cnt_clear = 1'b1;
                    err_inc   = 1'b1;
                end
            end
            CHECK_TRAILER: begin
                if (uart_valid) begin
                    if (uart_data == TRAILER_BYTE) begin
                        next_state = WRITE;
                    end else begin
                        err_inc    = 1'b1;
                        next_state = HUNT;
                    end
                end else if (idle_expired) begin
                    err_inc    = 1'b1;
                    cnt_clear  = 1'b1;
                    next_state = COLLECT;
                end
            end
            WRITE: begin
                // The completed word is delivered (or dropped) regardless of
                // a byte colliding with this cycle; that byte is lost and
                // forces a resync.
                cnt_clear = 1'b1;
                if (write_full) begin
                    ovf_inc = 1'b1;
                end else begin
                    write_en = 1'b1;
                end
                if (uart_valid) begin
                    err_inc    = 1'b1;
                    next_state = HUNT;
                end else begin
                    next_state = COLLECT;
                end
            end
            HUNT: begin
                cnt_clear = 1'b1;
                if (uart_valid) begin
                    if (uart_data == TRAILER_BYTE) begin
                        next_state = COLLECT;
                    end
                end else if (idle_expired) begin
                    next_state = COLLECT;
                end
            end
            default: begin
                cnt_clear  = 1'b1;
                next_state = COLLECT;
            end
        endcase
    end

    // Frame assembly: shift register and byte counter.
    always_ff @(negedge clock or negedge reset) begin
        if (!reset) begin
            shift_reg <= '0;
            byte_cnt  <= '0;
        end else begin
            if (shift_en) begin
                shift_reg <= {shift_reg[WORD_W-BYTE_W-1:0], uart_data};
            end
            if (cnt_clear) begin
                byte_cnt <= '0;
            end else if (shift_en) begin
                byte_cnt <= byte_cnt + 1'b1;
            end
        end
    end

    // FIFO write port: strobe is one cycle, data holds between strobes.
    always_ff @(negedge clock or negedge reset) begin
        if (!reset) begin
            write_data         <= '0;
            write_clock_enable <= 1'b0;
        end else begin
            write_clock_enable <= write_en;
            if (write_en) begin
                write_data <= shift_reg;
            end
        end
    end

    // Saturating error and overflow counters.
    always_ff @(negedge clock or negedge reset) begin
        if (!reset) begin
            frame_error_count <= '0;
            overflow_count    <= '0;
        end else begin
            if (err_inc) begin
                frame_error_count <= sat_inc(frame_error_count);
            end
            if (ovf_inc) begin
                overflow_count <= sat_inc(overflow_count);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial2mem.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial2mem
//  Description : Self-checking bench for serial2mem. A frame-level model
//                predicts written words and counter values; a monitor records
//                every write strobe seen on the FIFO port.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial2mem;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  uart_data = 8'h00;
    logic        uart_valid = 1'b0;
    logic        write_full = 1'b0;
    logic [47:0] write_data;
    logic        write_clock_enable;
    logic [7:0]  frame_error_count;
    logic [7:0]  overflow_count;

    int vectors    = 0;
    int miscompares = 0;

    logic [47:0] obs_q[$];
    logic [47:0] exp_q[$];
    int          exp_err = 0;
    int          exp_ovf = 0;

    always #5 clock = ~clock;

    serial2mem #(
        .TIMEOUT (24'd100)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .uart_data          (uart_data),
        .uart_valid         (uart_valid),
        .write_full         (write_full),
        .write_data         (write_data),
        .write_clock_enable (write_clock_enable),
        .frame_error_count  (frame_error_count),
        .overflow_count     (overflow_count)
    );

    // Monitor: record every strobed word (sampled mid-cycle on rising edge).
    always @(posedge clock) begin
        if (reset && write_clock_enable) begin
            obs_q.push_back(write_data);
        end
    end

    // One byte strobe spanning exactly one falling edge, then idle cycles.
    task automatic send_byte(input logic [7:0] b, input int gap);
        uart_data  = b;
        uart_valid = 1'b1;
        @(posedge clock);
        uart_valid = 1'b0;
        uart_data  = 8'($urandom);
        repeat (gap) @(posedge clock);
    endtask

    function automatic int sat(input int v);
        return (v < 255) ? v + 1 : 255;
    endfunction

    // Sends a frame and updates the frame-level model. A bad trailer is
    // followed by a lone 8'h0a to resynchronise. With late=1 a stray byte
    // lands in the cycle right after the trailer.
    task automatic send_frame(input logic [47:0] w, input logic [7:0] trailer,
                              input logic full, input logic late);
        for (int i = 0; i < 6; i++) begin
            send_byte(w[47-8*i -: 8], int'($urandom_range(0, 2)));
        end
        write_full = full;
        if (trailer == 8'h0a) begin
            if (full) exp_ovf = sat(exp_ovf);
            else      exp_q.push_back(w);
            if (late) begin
                send_byte(trailer, 0);
                send_byte(8'($urandom), 0);
                write_full = 1'b0;
                exp_err = sat(exp_err);
                send_byte(8'h0a, 1);
            end else begin
                send_byte(trailer, 2);
            end
        end else begin
            exp_err = sat(exp_err);
            send_byte(trailer, 1);
            send_byte(8'h0a, 1);
        end
        write_full = 1'b0;
    endtask

    task automatic do_reset;
        reset = 1'b0;
        repeat (2) @(posedge clock);
        reset = 1'b1;
        @(posedge clock);
        obs_q.delete();
        exp_q.delete();
        exp_err = 0;
        exp_ovf = 0;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (3) @(posedge clock);
        vectors++;
        if (write_clock_enable !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_wce: got %b expected 0", write_clock_enable);
        end
        vectors++;
        if (write_data !== 48'h0) begin
            miscompares++;
            $display("FAIL reset_data: got %h expected 0", write_data);
        end
        vectors++;
        if (frame_error_count !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_err: got %h expected 00", frame_error_count);
        end
        vectors++;
        if (overflow_count !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_ovf: got %h expected 00", overflow_count);
        end
        reset = 1'b1;
        @(posedge clock);
    endtask

    task automatic test_basic;
        logic [47:0] w;
        w = 48'h112233445566;
        do_reset();
        for (int i = 0; i < 6; i++) send_byte(w[47-8*i -: 8], 1);
        uart_data  = 8'h0a;
        uart_valid = 1'b1;
        @(posedge clock);
        uart_valid = 1'b0;
        vectors++;
        if (write_clock_enable !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_early: wce got %b expected 0", write_clock_enable);
        end
        @(posedge clock);
        vectors++;
        if (write_clock_enable !== 1'b1 || write_data !== w) begin
            miscompares++;
            $display("FAIL basic_pulse: wce=%b data=%h expected 1 %h", write_clock_enable, write_data, w);
        end
        @(posedge clock);
        vectors++;
        if (write_clock_enable !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_width: wce got %b expected 0", write_clock_enable);
        end
        repeat (5) @(posedge clock);
        vectors++;
        if (write_data !== w) begin
            miscompares++;
            $display("FAIL basic_hold: got %h expected %h", write_data, w);
        end
        vectors++;
        if (obs_q.size() != 1 || frame_error_count !== 8'h00 || overflow_count !== 8'h00) begin
            miscompares++;
            $display("FAIL basic_totals: writes=%0d err=%h ovf=%h expected 1 00 00",
                     obs_q.size(), frame_error_count, overflow_count);
        end
    endtask

    task automatic test_bad_trailer;
        do_reset();
        send_frame(48'h112233445566, 8'h0b, 1'b0, 1'b0);
        send_frame(48'hAABBCCDDEEFF, 8'h0a, 1'b0, 1'b0);
        repeat (4) @(posedge clock);
        vectors++;
        if (frame_error_count !== 8'(exp_err)) begin
            miscompares++;
            $display("FAIL bad_trailer_err: got %0d expected %0d", frame_error_count, exp_err);
        end
        vectors++;
        if (obs_q.size() != 1) begin
            miscompares++;
            $display("FAIL bad_trailer_writes: got %0d expected 1", obs_q.size());
        end else begin
            vectors++;
            if (obs_q[0] !== 48'hAABBCCDDEEFF) begin
                miscompares++;
                $display("FAIL bad_trailer_word: got %h expected aabbccddeeff", obs_q[0]);
            end
        end
    endtask

    task automatic test_overflow;
        do_reset();
        send_frame(48'h0102030a0506, 8'h0a, 1'b1, 1'b0);
        send_frame(48'hC0FFEE0A0BAD, 8'h0a, 1'b0, 1'b0);
        repeat (4) @(posedge clock);
        vectors++;
        if (overflow_count !== 8'(exp_ovf) || frame_error_count !== 8'(exp_err)) begin
            miscompares++;
            $display("FAIL overflow_counts: ovf=%0d err=%0d expected %0d %0d",
                     overflow_count, frame_error_count, exp_ovf, exp_err);
        end
        vectors++;
        if (obs_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL overflow_writes: got %0d expected %0d", obs_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < obs_q.size(); i++) begin
                vectors++;
                if (obs_q[i] !== exp_q[i]) begin
                    miscompares++;
                    $display("FAIL overflow_word[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_saturation;
        do_reset();
        for (int i = 0; i < 300; i++) begin
            send_frame({32'($urandom), 16'($urandom)}, 8'h00, 1'b0, 1'b0);
            if (i == 254) begin
                repeat (2) @(posedge clock);
                vectors++;
                if (frame_error_count !== 8'hff) begin
                    miscompares++;
                    $display("FAIL sat_err_255: got %h expected ff", frame_error_count);
                end
            end
        end
        for (int i = 0; i < 260; i++) begin
            send_frame({32'($urandom), 16'($urandom)}, 8'h0a, 1'b1, 1'b0);
        end
        repeat (4) @(posedge clock);
        vectors++;
        if (frame_error_count !== 8'(exp_err)) begin
            miscompares++;
            $display("FAIL sat_err: got %h expected %h", frame_error_count, 8'(exp_err));
        end
        vectors++;
        if (overflow_count !== 8'(exp_ovf)) begin
            miscompares++;
            $display("FAIL sat_ovf: got %h expected %h", overflow_count, 8'(exp_ovf));
        end
        vectors++;
        if (obs_q.size() != 0) begin
            miscompares++;
            $display("FAIL sat_writes: got %0d expected 0", obs_q.size());
        end
    endtask

    task automatic test_mid_reset;
        do_reset();
        send_byte(8'hA1, 1);
        send_byte(8'hA2, 1);
        send_byte(8'hA3, 1);
        #3 reset = 1'b0;
        repeat (2) @(posedge clock);
        reset = 1'b1;
        @(posedge clock);
        send_frame(48'h010203040506, 8'h0a, 1'b0, 1'b0);
        repeat (4) @(posedge clock);
        vectors++;
        if (obs_q.size() != 1) begin
            miscompares++;
            $display("FAIL mid_reset_writes: got %0d expected 1", obs_q.size());
        end else begin
            vectors++;
            if (obs_q[0] !== 48'h010203040506) begin
                miscompares++;
                $display("FAIL mid_reset_word: got %h expected 010203040506", obs_q[0]);
            end
        end
        vectors++;
        if (frame_error_count !== 8'h00) begin
            miscompares++;
            $display("FAIL mid_reset_err: got %h expected 00", frame_error_count);
        end
    endtask

    task automatic test_idle;
        do_reset();
        send_byte(8'h01, 1);
        send_byte(8'h02, 1);
        send_byte(8'h03, 1);
        repeat (150) @(posedge clock);
`ifdef SERIAL2MEM_TIMEOUT_EN
        exp_err = 1;
        send_frame(48'h010203040506, 8'h0a, 1'b0, 1'b0);
`else
        send_byte(8'h04, 1);
        send_byte(8'h05, 1);
        send_byte(8'h06, 1);
        send_byte(8'h0a, 2);
        exp_q.push_back(48'h010203040506);
`endif
        repeat (4) @(posedge clock);
        vectors++;
        if (frame_error_count !== 8'(exp_err)) begin
            miscompares++;
            $display("FAIL idle_err: got %0d expected %0d", frame_error_count, exp_err);
        end
        vectors++;
        if (obs_q.size() != 1) begin
            miscompares++;
            $display("FAIL idle_writes: got %0d expected 1", obs_q.size());
        end else begin
            vectors++;
            if (obs_q[0] !== exp_q[0]) begin
                miscompares++;
                $display("FAIL idle_word: got %h expected %h", obs_q[0], exp_q[0]);
            end
        end
    endtask

    task automatic test_random;
        logic [47:0] w;
        logic [7:0]  tr;
        do_reset();
        for (int f = 0; f < 60; f++) begin
            for (int i = 0; i < 6; i++) begin
                w[47-8*i -: 8] = ($urandom_range(0, 5) == 0) ? 8'h0a : 8'($urandom);
            end
            if ($urandom_range(0, 3) == 0) begin
                tr = 8'($urandom);
                if (tr == 8'h0a) tr = 8'h55;
            end else begin
                tr = 8'h0a;
            end
            send_frame(w, tr, ($urandom_range(0, 2) == 0), ($urandom_range(0, 5) == 0));
        end
        repeat (4) @(posedge clock);
        vectors++;
        if (frame_error_count !== 8'(exp_err) || overflow_count !== 8'(exp_ovf)) begin
            miscompares++;
            $display("FAIL random_counts: err=%0d ovf=%0d expected %0d %0d",
                     frame_error_count, overflow_count, exp_err, exp_ovf);
        end
        vectors++;
        if (obs_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL random_writes: got %0d expected %0d", obs_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < obs_q.size(); i++) begin
                vectors++;
                if (obs_q[i] !== exp_q[i]) begin
                    miscompares++;
                    $display("FAIL random_word[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bad_trailer();
        test_overflow();
        test_mid_reset();
        test_idle();
        test_random();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
